// File: rtl/barrier_pkg.sv
// Shared types and geometry helpers for the barrier collision scheduler.
// All geometry is 11-bit unsigned: subtractions clamp at 0, additions carry
// into bit 10 so they never wrap.
package barrier_pkg;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] hh;
        logic [9:0] lh;
        logic       en;
    } barrier_t;

    // Frame snapshot of both tanks and both bullets.
    typedef struct packed {
        logic [9:0] p1x, p1y, p2x, p2y, psz;
        logic [9:0] b1x, b1y, b2x, b2y, bsz;
    } snap_t;

    localparam logic [3:0] COLL_NONE   = 4'b0000;
    localparam logic [3:0] COLL_RIGHT  = 4'b0001;
    localparam logic [3:0] COLL_LEFT   = 4'b0010;
    localparam logic [3:0] COLL_BOTTOM = 4'b0100;
    localparam logic [3:0] COLL_TOP    = 4'b1000;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_PUBLISH} sched_state_t;

    function automatic logic [10:0] sub_cl(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? {1'b0, a - b} : 11'd0;
    endfunction

    function automatic logic [10:0] add_nw(input logic [9:0] a, input logic [9:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Side code of a mover (centre cx,cy, half-size s) against one barrier.
    // "Right" means the mover's right edge reached the barrier's left face
    // while its centre is still at or left of that face; the other sides
    // mirror this. Tests run right, left, bottom, top; first match wins.
    function automatic logic [3:0] side_code(input barrier_t b, input logic [9:0] cx,
                                             input logic [9:0] cy, input logic [9:0] s);
        logic [10:0] el, er, et, eb, ml, mr, mt, mb, px, py;
        logic vo, ho;
        el = sub_cl(b.x, b.lh);
        er = add_nw(b.x, b.lh);
        et = sub_cl(b.y, b.hh);
        eb = add_nw(b.y, b.hh);
        ml = sub_cl(cx, s);
        mr = add_nw(cx, s);
        mt = sub_cl(cy, s);
        mb = add_nw(cy, s);
        px = {1'b0, cx};
        py = {1'b0, cy};
        vo = (mb >= et) && (mt <= eb);
        ho = (mr >= el) && (ml <= er);
        if (!b.en)                             return COLL_NONE;
        if (vo && (mr >= el) && (px <= el))    return COLL_RIGHT;
        if (vo && (ml <= er) && (px >= er))    return COLL_LEFT;
        if (ho && (mb >= et) && (py <= et))    return COLL_BOTTOM;
        if (ho && (mt <= eb) && (py >= eb))    return COLL_TOP;
        return COLL_NONE;
    endfunction

    // Bullet box overlaps barrier box (inclusive edges).
    function automatic logic bullet_hit(input barrier_t b, input logic [9:0] cx,
                                        input logic [9:0] cy, input logic [9:0] s);
        return b.en
            && (add_nw(cx, s) >= sub_cl(b.x, b.lh)) && (sub_cl(cx, s) <= add_nw(b.x, b.lh))
            && (add_nw(cy, s) >= sub_cl(b.y, b.hh)) && (sub_cl(cy, s) <= add_nw(b.y, b.hh));
    endfunction

endpackage

// File: rtl/barrier_hit_check.sv
// Single shared hit-check unit: one barrier against the frame snapshot,
// results registered with one cycle of latency.
module barrier_hit_check
    import barrier_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  barrier_t   i_bar,
    input  snap_t      i_snap,
    output logic [3:0] o_p1_code,
    output logic [3:0] o_p2_code,
    output logic       o_b1_hit,
    output logic       o_b2_hit
);

    logic [3:0] r_p1, r_p2;
    logic       r_b1, r_b2;

    // Evaluate all four movers against the issued barrier.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_p1 <= COLL_NONE;
            r_p2 <= COLL_NONE;
            r_b1 <= 1'b0;
            r_b2 <= 1'b0;
        end else begin
            r_p1 <= side_code(i_bar, i_snap.p1x, i_snap.p1y, i_snap.psz);
            r_p2 <= side_code(i_bar, i_snap.p2x, i_snap.p2y, i_snap.psz);
            r_b1 <= bullet_hit(i_bar, i_snap.b1x, i_snap.b1y, i_snap.bsz);
            r_b2 <= bullet_hit(i_bar, i_snap.b2x, i_snap.b2y, i_snap.bsz);
        end
    end

    assign o_p1_code = r_p1;
    assign o_p2_code = r_p2;
    assign o_b1_hit  = r_b1;
    assign o_b2_hit  = r_b2;

endmodule

// File: rtl/barrier_scheduler.sv
// Per-frame barrier collision sequencer: scans the barrier table through one
// shared hit checker and publishes merged results once per frame.
// Optional: define BARRIER_DESTRUCT_EN to disable barriers hit by a bullet.
module barrier_scheduler
    import barrier_pkg::*;
#(
    parameter int NUM_BARRIERS = 8,
    parameter int IDX_W        = $clog2(NUM_BARRIERS)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_start,
    input  logic [9:0]       BallX,
    input  logic [9:0]       BallY,
    input  logic [9:0]       Ball2X,
    input  logic [9:0]       Ball2Y,
    input  logic [9:0]       Ball_Size,
    input  logic [9:0]       BulletX,
    input  logic [9:0]       BulletY,
    input  logic [9:0]       Bullet2X,
    input  logic [9:0]       Bullet2Y,
    input  logic [9:0]       Bullet_Size,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [9:0]       cfg_x,
    input  logic [9:0]       cfg_y,
    input  logic [9:0]       cfg_hh,
    input  logic [9:0]       cfg_lh,
    input  logic             cfg_en,
    output logic             cfg_ready,
    output logic [3:0]       player_1_collision,
    output logic [3:0]       player_2_collision,
    output logic             bullet_1_collision,
    output logic             bullet_2_collision,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    sched_state_t     r_state;
    logic [IDX_W-1:0] r_idx;
    snap_t            r_snap;
    barrier_t         r_tab [NUM_BARRIERS];
    logic             r_chk_vld;
    logic [3:0]       r_acc_p1, r_acc_p2, r_out_p1, r_out_p2;
    logic             r_acc_b1, r_acc_b2, r_out_b1, r_out_b2;
    logic             r_done, r_overrun;
    logic [3:0]       w_p1, w_p2;
    logic             w_b1, w_b2;
    barrier_t         w_bar;
`ifdef BARRIER_DESTRUCT_EN
    logic [IDX_W-1:0]        r_chk_idx;
    logic [NUM_BARRIERS-1:0] r_kill;
`endif

    assign w_bar = r_tab[r_idx];

    barrier_hit_check u_chk (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .i_bar     (w_bar),
        .i_snap    (r_snap),
        .o_p1_code (w_p1),
        .o_p2_code (w_p2),
        .o_b1_hit  (w_b1),
        .o_b2_hit  (w_b2)
    );

    // Barrier table: cfg writes only while idle; optional bullet destruction at publish.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_BARRIERS; i++) r_tab[i] <= '0;
        end else if (r_state == ST_IDLE) begin
            if (cfg_we && int'(cfg_idx) < NUM_BARRIERS)
                r_tab[cfg_idx] <= '{x: cfg_x, y: cfg_y, hh: cfg_hh, lh: cfg_lh, en: cfg_en};
`ifdef BARRIER_DESTRUCT_EN
        end else if (r_state == ST_PUBLISH) begin
            for (int i = 0; i < NUM_BARRIERS; i++)
                if (r_kill[i]) r_tab[i].en <= 1'b0;
`endif
        end
    end

    // Scan FSM, accumulators and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_snap    <= '0;
            r_chk_vld <= 1'b0;
            r_acc_p1  <= COLL_NONE;
            r_acc_p2  <= COLL_NONE;
            r_acc_b1  <= 1'b0;
            r_acc_b2  <= 1'b0;
            r_out_p1  <= COLL_NONE;
            r_out_p2  <= COLL_NONE;
            r_out_b1  <= 1'b0;
            r_out_b2  <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
`ifdef BARRIER_DESTRUCT_EN
            r_chk_idx <= '0;
            r_kill    <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_chk_vld <= (r_state == ST_SCAN);
`ifdef BARRIER_DESTRUCT_EN
            r_chk_idx <= r_idx;
`endif
            // Checker result for the entry issued last cycle.
            if (r_chk_vld) begin
                if (r_acc_p1 == COLL_NONE) r_acc_p1 <= w_p1;
                if (r_acc_p2 == COLL_NONE) r_acc_p2 <= w_p2;
                r_acc_b1 <= r_acc_b1 | w_b1;
                r_acc_b2 <= r_acc_b2 | w_b2;
`ifdef BARRIER_DESTRUCT_EN
                if (w_b1 || w_b2) r_kill[r_chk_idx] <= 1'b1;
`endif
            end
            if (r_state != ST_IDLE && frame_start) r_overrun <= 1'b1;
            case (r_state)
                ST_IDLE: if (frame_start) begin
                    r_snap   <= '{p1x: BallX, p1y: BallY, p2x: Ball2X, p2y: Ball2Y, psz: Ball_Size,
                                 b1x: BulletX, b1y: BulletY, b2x: Bullet2X, b2y: Bullet2Y,
                                 bsz: Bullet_Size};
                    r_acc_p1 <= COLL_NONE;
                    r_acc_p2 <= COLL_NONE;
                    r_acc_b1 <= 1'b0;
                    r_acc_b2 <= 1'b0;
`ifdef BARRIER_DESTRUCT_EN
                    r_kill   <= '0;
`endif
                    r_idx    <= '0;
                    r_state  <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (r_idx == IDX_W'(NUM_BARRIERS - 1)) begin
                        r_idx   <= '0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DRAIN: r_state <= ST_PUBLISH;
                ST_PUBLISH: begin
                    r_out_p1 <= r_acc_p1;
                    r_out_p2 <= r_acc_p2;
                    r_out_b1 <= r_acc_b1;
                    r_out_b2 <= r_acc_b2;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy               = (r_state != ST_IDLE);
    assign cfg_ready          = !busy;
    assign done               = r_done;
    assign overrun            = r_overrun;
    assign player_1_collision = r_out_p1;
    assign player_2_collision = r_out_p2;
    assign bullet_1_collision = r_out_b1;
    assign bullet_2_collision = r_out_b2;

endmodule

// File: tb/tb_barrier_scheduler.sv
// Scoreboard bench for barrier_scheduler: stimulus pushes expected frame
// results, a monitor pops and compares them on every done pulse.
module tb_barrier_scheduler;

    localparam int N = 8;
`ifdef BARRIER_DESTRUCT_EN
    localparam bit DESTRUCT = 1'b1;
`else
    localparam bit DESTRUCT = 1'b0;
`endif

    logic       Clk = 1'b0, Reset_n = 1'b0, frame_start = 1'b0;
    logic [9:0] BallX, BallY, Ball2X, Ball2Y, Ball_Size;
    logic [9:0] BulletX, BulletY, Bullet2X, Bullet2Y, Bullet_Size;
    logic       cfg_we = 1'b0, cfg_en = 1'b0;
    logic [2:0] cfg_idx = '0;
    logic [9:0] cfg_x = '0, cfg_y = '0, cfg_hh = '0, cfg_lh = '0;
    logic       cfg_ready, bullet_1_collision, bullet_2_collision, busy, done, overrun;
    logic [3:0] player_1_collision, player_2_collision;

    barrier_scheduler #(.NUM_BARRIERS(N)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .BallX(BallX), .BallY(BallY), .Ball2X(Ball2X), .Ball2Y(Ball2Y), .Ball_Size(Ball_Size),
        .BulletX(BulletX), .BulletY(BulletY), .Bullet2X(Bullet2X), .Bullet2Y(Bullet2Y),
        .Bullet_Size(Bullet_Size),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_hh(cfg_hh),
        .cfg_lh(cfg_lh), .cfg_en(cfg_en), .cfg_ready(cfg_ready),
        .player_1_collision(player_1_collision), .player_2_collision(player_2_collision),
        .bullet_1_collision(bullet_1_collision), .bullet_2_collision(bullet_2_collision),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    typedef struct {
        logic [3:0] p1, p2;
        logic       b1, b2;
        int         cyc;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding frame.
    always @(negedge Clk) begin
        if (Reset_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("player_1_collision", int'(player_1_collision), int'(e.p1));
                chk("player_2_collision", int'(player_2_collision), int'(e.p2));
                chk("bullet_1_collision", int'(bullet_1_collision), int'(e.b1));
                chk("bullet_2_collision", int'(bullet_2_collision), int'(e.b2));
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    // All tasks start just after a negedge and return just after a negedge.
    task automatic set_cfg(input int idx, input int x, input int y, input int hh,
                           input int lh, input logic en);
        cfg_we  = 1'b1;
        cfg_idx = 3'(idx);
        cfg_x   = 10'(x);
        cfg_y   = 10'(y);
        cfg_hh  = 10'(hh);
        cfg_lh  = 10'(lh);
        cfg_en  = en;
    endtask

    task automatic wr(input int idx, input int x, input int y, input int hh,
                      input int lh, input logic en);
        set_cfg(idx, x, y, hh, lh, en);
        @(negedge Clk);
        cfg_we = 1'b0;
    endtask

    task automatic wait_done(input string name, output int bcnt);
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (busy) bcnt++;
            @(negedge Clk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
        @(negedge Clk);
    endtask

    task automatic push(input logic [3:0] p1, input logic [3:0] p2, input logic b1,
                        input logic b2);
        exp_t e;
        e.p1  = p1;
        e.p2  = p2;
        e.b1  = b1;
        e.b2  = b2;
        e.cyc = cyc + 1 + N + 2;
        q.push_back(e);
    endtask

    task automatic run(input string name, input logic [3:0] p1, input logic [3:0] p2,
                       input logic b1, input logic b2, output int bcnt);
        push(p1, p2, b1, b2);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        cfg_we      = 1'b0;
        wait_done(name, bcnt);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_p1"}, int'(player_1_collision), 0);
        chk({tag, "_p2"}, int'(player_2_collision), 0);
        chk({tag, "_b1"}, int'(bullet_1_collision), 0);
        chk({tag, "_b2"}, int'(bullet_2_collision), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_overrun"}, int'(overrun), 0);
        chk({tag, "_cfg_ready"}, int'(cfg_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        BallX = 10'd500; BallY = 10'd400; Ball2X = 10'd500; Ball2Y = 10'd400; Ball_Size = 10'd5;
        BulletX = 10'd600; BulletY = 10'd450; Bullet2X = 10'd800; Bullet2Y = 10'd50;
        Bullet_Size = 10'd2;
        repeat (3) @(negedge Clk);
        chk_idle_outputs("reset");
        Reset_n = 1'b1;
        @(negedge Clk);

        // Empty table: no hits, done after N+2 cycles.
        run("empty", 4'b0000, 4'b0000, 1'b0, 1'b0, b);
        chk("busy_cycles_empty", b, N + 2);

        // Tank 1 right edge exactly on barrier 0 left face (80 == 100-20).
        wr(0, 100, 100, 20, 20, 1'b1);
        BallX = 10'd75; BallY = 10'd100;
        run("p1_right", 4'b0001, 4'b0000, 1'b0, 1'b0, b);
        chk("busy_cycles_p1", b, N + 2);

        // Tank 2: entry2 right, entry5 top; lowest index wins.
        Ball2X = 10'd200; Ball2Y = 10'd200;
        wr(2, 215, 200, 10, 10, 1'b1);
        wr(5, 200, 185, 10, 10, 1'b1);
        run("p2_lowest", 4'b0001, 4'b0001, 1'b0, 1'b0, b);
        wr(2, 215, 200, 10, 10, 1'b0);
        run("p2_disabled", 4'b0001, 4'b1000, 1'b0, 1'b0, b);

        // Bullet vs barrier with clamped left edge (x=5, lh=20 -> 0..25).
        wr(7, 5, 300, 10, 20, 1'b1);
        BulletY = 10'd300;
        BulletX = 10'd30;
        run("bullet_miss", 4'b0001, 4'b1000, 1'b0, 1'b0, b);
        BulletX = 10'd0;
        run("bullet_clamp", 4'b0001, 4'b1000, 1'b1, 1'b0, b);
        BulletX = 10'd27;
        run("bullet_edge", 4'b0001, 4'b1000, !DESTRUCT, 1'b0, b);
        BulletX = 10'd600; BulletY = 10'd450;

        // Second frame_start and cfg write mid-scan are ignored.
        push(4'b0001, 4'b1000, 1'b0, 1'b0);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("cfg_ready_scan", int'(cfg_ready), 0);
        chk("busy_scan", int'(busy), 1);
        frame_start = 1'b1;
        set_cfg(0, 100, 100, 20, 20, 1'b0);
        @(negedge Clk);
        frame_start = 1'b0;
        cfg_we = 1'b0;
        wait_done("overrun", b);
        chk("overrun_set", int'(overrun), 1);
        run("table_kept", 4'b0001, 4'b1000, 1'b0, 1'b0, b);
        chk("overrun_sticky", int'(overrun), 1);

        // Reset at cycle 4 of a scan aborts it and clears the table.
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        run("after_reset", 4'b0000, 4'b0000, 1'b0, 1'b0, b);

        // Write in the same cycle as frame_start is seen by that scan.
        set_cfg(1, 800, 50, 5, 5, 1'b1);
        run("b2_frame1", 4'b0000, 4'b0000, 1'b0, 1'b1, b);
        run("b2_frame2", 4'b0000, 4'b0000, 1'b0, !DESTRUCT, b);
        wr(1, 800, 50, 5, 5, 1'b1);
        run("b2_reenabled", 4'b0000, 4'b0000, 1'b0, 1'b1, b);

        repeat (15) @(negedge Clk);
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
